if_id_skid: RTL and testbench

- IF/ID pipeline stage between instruction fetch and decode.
- Registers each fetched instruction and its PC behind a valid/ready handshake, with a 2-entry skid buffer so upstream ready never depends combinationally on downstream ready.
- Splits the registered instruction into RV32 fields: rd, rs1, rs2, funct3, funct7, opcode, and the S-type immediate halves imm7b/imm5b. The S-immediate concatenation/sign-extension stage consumes imm7b/imm5b directly.

---
 rtl/if_id_skid.sv | 169 ++++++++++++++++
 tb/tb_if_id_skid.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_skid.sv
// IF/ID pipeline register with a 2-entry skid buffer and RV32 field split.
// Optional performance counters are compiled in with IFID_PERF_CNT_EN.
module if_id_skid #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] PC_RESET = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
`ifdef IFID_PERF_CNT_EN
  output logic [31:0]     bubble_cnt,
  output logic [31:0]     stall_cnt,
`endif
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [2:0]      funct3,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [6:0]      funct7,
  output logic [6:0]      imm7b,
  output logic [4:0]      imm5b,
  output logic            illegal
);

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  logic            main_v_q, main_v_d;
  logic            skid_v_q, skid_v_d;
  logic            in_ready_q, in_ready_d;
  logic            illegal_q, illegal_d;
  logic [XLEN-1:0] main_instr_q, main_instr_d;
  logic [XLEN-1:0] main_pc_q, main_pc_d;
  logic [XLEN-1:0] skid_instr_q, skid_instr_d;
  logic [XLEN-1:0] skid_pc_q, skid_pc_d;
  logic            up_fire_s;
  logic            dn_fire_s;

  // in_ready comes from a register, so the upstream path never sees out_ready.
  assign up_fire_s = in_valid && in_ready_q;
  assign dn_fire_s = main_v_q && out_ready;

  // Next-state selection: flush, refill main, promote skid, fill skid, hold.
  always_comb begin
    main_v_d     = main_v_q;
    skid_v_d     = skid_v_q;
    main_instr_d = main_instr_q;
    main_pc_d    = main_pc_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    if (flush) begin
      main_v_d     = 1'b0;
      skid_v_d     = 1'b0;
      main_instr_d = NOP_INSTR;
      main_pc_d    = PC_RESET;
    end else if (!main_v_q || (dn_fire_s && !skid_v_q)) begin
      if (up_fire_s) begin
        main_v_d     = 1'b1;
        main_instr_d = in_instr;
        main_pc_d    = in_pc;
      end else begin
        // An empty main register presents the NOP / reset PC.
        main_v_d     = 1'b0;
        main_instr_d = NOP_INSTR;
        main_pc_d    = PC_RESET;
      end
    end else if (dn_fire_s) begin
      main_v_d     = 1'b1;
      main_instr_d = skid_instr_q;
      main_pc_d    = skid_pc_q;
      skid_v_d     = 1'b0;
    end else if (up_fire_s) begin
      skid_v_d     = 1'b1;
      skid_instr_d = in_instr;
      skid_pc_d    = in_pc;
    end else begin
      main_v_d     = main_v_q;
      skid_v_d     = skid_v_q;
    end
  end

  // Registered flags derived from the next state.
  always_comb begin
    in_ready_d = !skid_v_d;
    illegal_d  = main_v_d && (main_instr_d[1:0] != 2'b11);
  end

  // Pipeline state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_v_q     <= 1'b0;
      skid_v_q     <= 1'b0;
      in_ready_q   <= 1'b1;
      illegal_q    <= 1'b0;
      main_instr_q <= NOP_INSTR;
      main_pc_q    <= PC_RESET;
      skid_instr_q <= NOP_INSTR;
      skid_pc_q    <= PC_RESET;
    end else begin
      main_v_q     <= main_v_d;
      skid_v_q     <= skid_v_d;
      in_ready_q   <= in_ready_d;
      illegal_q    <= illegal_d;
      main_instr_q <= main_instr_d;
      main_pc_q    <= main_pc_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_v_q;
  assign out_instr = main_instr_q;
  assign out_pc    = main_pc_q;
  assign illegal   = illegal_q;

  // Field outputs are plain slices; imm7b/imm5b feed the S-immediate builder.
  assign opcode = main_instr_q[6:0];
  assign rd     = main_instr_q[11:7];
  assign funct3 = main_instr_q[14:12];
  assign rs1    = main_instr_q[19:15];
  assign rs2    = main_instr_q[24:20];
  assign funct7 = main_instr_q[31:25];
  assign imm7b  = main_instr_q[31:25];
  assign imm5b  = main_instr_q[11:7];

`ifdef IFID_PERF_CNT_EN
  logic [31:0] bubble_q, bubble_d;
  logic [31:0] stall_q, stall_d;

  // Counters wrap naturally and ignore flush.
  always_comb begin
    bubble_d = bubble_q;
    stall_d  = stall_q;
    if (!main_v_q && out_ready) begin
      bubble_d = bubble_q + 32'd1;
    end else begin
      bubble_d = bubble_q;
    end
    if (main_v_q && !out_ready) begin
      stall_d = stall_q + 32'd1;
    end else begin
      stall_d = stall_q;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_q <= 32'd0;
      stall_q  <= 32'd0;
    end else begin
      bubble_q <= bubble_d;
      stall_q  <= stall_d;
    end
  end

  assign bubble_cnt = bubble_q;
  assign stall_cnt  = stall_q;
`endif

endmodule

// File: tb/tb_if_id_skid.sv
// Bench for if_id_skid: a 2-deep FIFO model checked every negedge, plus
// hand-computed literal checks for the directed scenarios.
module tb_if_id_skid;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] PCR  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = 32'h0;
  logic [31:0] in_pc = 32'h0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  funct7;
  logic [6:0]  imm7b;
  logic [4:0]  imm5b;
  logic        illegal;
`ifdef IFID_PERF_CNT_EN
  logic [31:0] bubble_cnt;
  logic [31:0] stall_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  if_id_skid #(.XLEN(32), .PC_RESET(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef IFID_PERF_CNT_EN
    .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .opcode(opcode), .rd(rd),
    .funct3(funct3), .rs1(rs1), .rs2(rs2), .funct7(funct7),
    .imm7b(imm7b), .imm5b(imm5b), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: the stage is a 2-deep FIFO of {instr, pc}.
  logic [63:0] mq[$];
  int          msz;
  logic [31:0] m_bubble = 32'd0;
  logic [31:0] m_stall  = 32'd0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_bubble = 32'd0;
      m_stall  = 32'd0;
    end else begin
      msz = mq.size();
      if (msz == 0 && out_ready) m_bubble = m_bubble + 32'd1;
      if (msz > 0 && !out_ready) m_stall = m_stall + 32'd1;
      if (flush) begin
        mq.delete();
      end else begin
        if (msz > 0 && out_ready) void'(mq.pop_front());
        if (in_valid && msz < 2) mq.push_back({in_instr, in_pc});
      end
    end
  end

  // Compare process: every negedge, DUT outputs against the model.
  always @(negedge clk) begin
    logic        ev;
    logic [31:0] ei;
    logic [31:0] ep;
    ev = (mq.size() > 0);
    ei = ev ? mq[0][63:32] : NOP;
    ep = ev ? mq[0][31:0]  : PCR;
    chk("m_out_valid", {63'd0, out_valid}, {63'd0, ev});
    chk("m_in_ready",  {63'd0, in_ready},  {63'd0, (mq.size() < 2)});
    chk("m_out_instr", {32'd0, out_instr}, {32'd0, ei});
    chk("m_out_pc",    {32'd0, out_pc},    {32'd0, ep});
    chk("m_opcode",    {57'd0, opcode},    {57'd0, ei[6:0]});
    chk("m_rd",        {59'd0, rd},        {59'd0, ei[11:7]});
    chk("m_funct3",    {61'd0, funct3},    {61'd0, ei[14:12]});
    chk("m_rs1",       {59'd0, rs1},       {59'd0, ei[19:15]});
    chk("m_rs2",       {59'd0, rs2},       {59'd0, ei[24:20]});
    chk("m_funct7",    {57'd0, funct7},    {57'd0, ei[31:25]});
    chk("m_imm7b",     {57'd0, imm7b},     {57'd0, ei[31:25]});
    chk("m_imm5b",     {59'd0, imm5b},     {59'd0, ei[11:7]});
    chk("m_illegal",   {63'd0, illegal},   {63'd0, (ev && ei[1:0] != 2'b11)});
`ifdef IFID_PERF_CNT_EN
    chk("m_bubble", {32'd0, bubble_cnt}, {32'd0, m_bubble});
    chk("m_stall",  {32'd0, stall_cnt},  {32'd0, m_stall});
`endif
  end

  task automatic drive(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                       input logic ordy, input logic fl);
    in_valid  = iv;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
    chk("rst_out_instr", {32'd0, out_instr}, 64'h13);
    chk("rst_out_pc",    {32'd0, out_pc},    64'd0);
    rst_n = 1'b1;

    // sw x1,-4(x2)
    drive(1'b1, 32'hFE11_2E23, 32'h0000_0100, 1'b1, 1'b0);
    chk("sw_valid",  {63'd0, out_valid}, 64'd1);
    chk("sw_opcode", {57'd0, opcode},    64'h23);
    chk("sw_imm7b",  {57'd0, imm7b},     64'h7F);
    chk("sw_imm5b",  {59'd0, imm5b},     64'h1C);
    chk("sw_rs1",    {59'd0, rs1},       64'd2);
    chk("sw_rs2",    {59'd0, rs2},       64'd1);
    chk("sw_illegal",{63'd0, illegal},   64'd0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("sw_drained", {63'd0, out_valid}, 64'd0);

    // Backpressure: A, B, C with out_ready low
    drive(1'b1, 32'h0000_A0B3, 32'h0000_0200, 1'b0, 1'b0);
    drive(1'b1, 32'h0000_B0B3, 32'h0000_0204, 1'b0, 1'b0);
    chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
    chk("bp_main_A", {32'd0, out_instr}, 64'hA0B3);
    drive(1'b1, 32'h0000_C0B3, 32'h0000_0208, 1'b0, 1'b0);
    chk("bp_hold_A", {32'd0, out_instr}, 64'hA0B3);
    chk("bp_hold_rdy", {63'd0, in_ready}, 64'd0);
    drive(1'b1, 32'h0000_C0B3, 32'h0000_0208, 1'b1, 1'b0);
    chk("bp_out_B", {32'd0, out_instr}, 64'hB0B3);
    chk("bp_pc_B",  {32'd0, out_pc},    64'h204);
    drive(1'b1, 32'h0000_C0B3, 32'h0000_0208, 1'b1, 1'b0);
    chk("bp_out_C", {32'd0, out_instr}, 64'hC0B3);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("bp_empty", {63'd0, out_valid}, 64'd0);

    // Flush with both entries full and an input offered
    drive(1'b1, 32'h0000_1113, 32'h0000_0300, 1'b0, 1'b0);
    drive(1'b1, 32'h0000_2213, 32'h0000_0304, 1'b0, 1'b0);
    drive(1'b1, 32'h0000_3313, 32'h0000_0308, 1'b0, 1'b1);
    chk("fl_valid", {63'd0, out_valid}, 64'd0);
    chk("fl_ready", {63'd0, in_ready},  64'd1);
    chk("fl_instr", {32'd0, out_instr}, 64'h13);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("fl_dropped", {63'd0, out_valid}, 64'd0);

    // Illegal encoding
    drive(1'b1, 32'h0000_0000, 32'h0000_0400, 1'b0, 1'b0);
    chk("il_set", {63'd0, illegal}, 64'd1);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("il_hold", {63'd0, illegal}, 64'd1);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("il_clear", {63'd0, illegal}, 64'd0);

    // Async reset mid-stream with both entries full
    drive(1'b1, 32'h0000_4413, 32'h0000_0500, 1'b0, 1'b0);
    drive(1'b1, 32'h0000_5513, 32'h0000_0504, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", {63'd0, out_valid}, 64'd0);
    chk("ar_ready", {63'd0, in_ready},  64'd1);
    chk("ar_instr", {32'd0, out_instr}, 64'h13);
    chk("ar_pc",    {32'd0, out_pc},    64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 32'h0000_6613, 32'h0000_0600, 1'b1, 1'b0);
    chk("ar_restart", {32'd0, out_instr}, 64'h6613);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Mixed traffic checked by the model
    for (int i = 0; i < 40; i++) begin
      drive((i % 3) != 0, 32'h1000_0003 + (32'(i) << 8), 32'h0000_0700 + 32'(i) * 32'd4,
            (i % 4) != 1, i == 25);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Counter window starts from a fresh reset
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
`ifdef IFID_PERF_CNT_EN
    chk("pc_bubble5", {32'd0, bubble_cnt}, 64'd5);
    chk("pc_stall0",  {32'd0, stall_cnt},  64'd0);
`endif
    drive(1'b1, 32'h0000_7713, 32'h0000_0800, 1'b0, 1'b0);
    repeat (3) drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
`ifdef IFID_PERF_CNT_EN
    chk("pc_stall3",  {32'd0, stall_cnt},  64'd3);
    chk("pc_bubble5b",{32'd0, bubble_cnt}, 64'd5);
`endif
    chk("pc_held", {32'd0, out_instr}, 64'h7713);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
